// File: rtl/mezzanina_giga_fitter_pkg.sv
// Shared constants for the GigaFitter input mezzanine.
// Word geometry and default FIFO sizing.
package mezzanina_giga_fitter_pkg;

    localparam int WORD_W     = 23;
    localparam int STB_BIT    = 23;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_MARGIN = 4;

    localparam logic [23:0] W1_IDLE = 24'h800000;

endpackage

// File: rtl/mezzanina_giga_fitter_gf_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Head word is visible on o_rdata whenever o_empty is low.
module gf_sync_fifo
    import mezzanina_giga_fitter_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AFULL = DEF_DEPTH - DEF_MARGIN,
    parameter int W     = WORD_W,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_rd,
    output logic [W-1:0]  o_rdata,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_afull
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_afull;

    logic          w_wr_ok;
    logic          w_rd_ok;
    logic [CW-1:0] w_count_nxt;

    assign w_wr_ok = i_wr && (r_count < CW'(DEPTH));
    assign w_rd_ok = i_rd && (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        unique case (1'b1)
            w_wr_ok && !w_rd_ok: w_count_nxt = r_count + 1'b1;
            !w_wr_ok && w_rd_ok: w_count_nxt = r_count - 1'b1;
            default:             w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Flags are registered from the post-edge occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_afull <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            r_afull <= (w_count_nxt >= CW'(AFULL));
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_afull = r_afull;

endmodule

// File: rtl/mezzanina_giga_fitter.sv
// GigaFitter input mezzanine: W1 capture, FIFO, J1 handshake,
// word counter, overflow flag and registered J3 loopback.
module mezzanina_giga_fitter
    import mezzanina_giga_fitter_pkg::*;
#(
    parameter int FIFO_DEPTH  = DEF_DEPTH,
    parameter int HOLD_MARGIN = DEF_MARGIN
) (
    input  logic        J3WRITECLK,
    input  logic        RESET,
    input  logic [23:0] W1_DATA,
    output logic        W_HOLD_2,
    output logic        FLOATIN_3,
    output logic        FLOATIN_4,
    output logic [15:1] OUT,
    output logic [23:0] J1DATA_out,
    input  logic        J1DATA_25,
    output logic [23:0] J1DATA,
    input  logic [23:0] J3DATA_in,
    output logic [23:0] J3DATA,
    output logic        J3DATA_out_24
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [23:0]       r_w1;
    logic [14:0]       r_cnt;
    logic [23:0]       r_j1;
    logic              r_ovf;
    logic [23:0]       r_j3;
    logic              r_par;

    logic              w_wr_req;
    logic              w_full;
    logic              w_empty;
    logic              w_afull;
    logic              w_dv;
    logic [WORD_W-1:0] w_rdata;
    logic [CW-1:0]     w_count;

    assign w_wr_req = ~r_w1[STB_BIT];

    gf_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AFULL (FIFO_DEPTH - HOLD_MARGIN),
        .W     (WORD_W)
    ) u_fifo (
        .i_clk   (J3WRITECLK),
        .i_rst   (RESET),
        .i_wr    (w_wr_req),
        .i_wdata (r_w1[WORD_W-1:0]),
        .i_rd    (J1DATA_25),
        .o_rdata (w_rdata),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_afull (w_afull)
    );

    assign w_dv = (w_count != '0);

    // Full is the pre-edge state, so a same-edge read cannot rescue the word.
    always_ff @(posedge J3WRITECLK) begin
        if (RESET) begin
            r_w1  <= W1_IDLE;
            r_cnt <= '0;
            r_j1  <= '0;
            r_ovf <= 1'b0;
            r_j3  <= '0;
            r_par <= 1'b0;
        end else begin
            r_w1 <= W1_DATA;
            if (w_wr_req && !w_full) begin
                r_cnt <= r_cnt + 1'b1;
                r_j1  <= {1'b0, r_w1[WORD_W-1:0]};
            end
            if (w_wr_req && w_full) begin
                r_ovf <= 1'b1;
            end
            r_j3  <= J3DATA_in;
            r_par <= ^J3DATA_in;
        end
    end

    assign J1DATA_out    = w_dv ? {1'b1, w_rdata} : 24'h0;
    assign W_HOLD_2      = w_afull;
    assign FLOATIN_3     = w_empty;
    assign FLOATIN_4     = r_ovf;
    assign OUT           = r_cnt;
    assign J1DATA        = r_j1;
    assign J3DATA        = r_j3;
    assign J3DATA_out_24 = r_par;

endmodule

// File: tb/tb_mezzanina_giga_fitter.sv
// Scoreboard bench for mezzanina_giga_fitter with a queue-based model.
`timescale 1ns/1ps
module tb_mezzanina_giga_fitter;

    logic        clk = 1'b0;
    logic        RESET;
    logic [23:0] W1_DATA;
    logic        W_HOLD_2;
    logic        FLOATIN_3;
    logic        FLOATIN_4;
    logic [15:1] OUT;
    logic [23:0] J1DATA_out;
    logic        J1DATA_25;
    logic [23:0] J1DATA;
    logic [23:0] J3DATA_in;
    logic [23:0] J3DATA;
    logic        J3DATA_out_24;

    int vectors = 0;
    int miscompares = 0;

    mezzanina_giga_fitter dut (
        .J3WRITECLK    (clk),
        .RESET         (RESET),
        .W1_DATA       (W1_DATA),
        .W_HOLD_2      (W_HOLD_2),
        .FLOATIN_3     (FLOATIN_3),
        .FLOATIN_4     (FLOATIN_4),
        .OUT           (OUT),
        .J1DATA_out    (J1DATA_out),
        .J1DATA_25     (J1DATA_25),
        .J1DATA        (J1DATA),
        .J3DATA_in     (J3DATA_in),
        .J3DATA        (J3DATA),
        .J3DATA_out_24 (J3DATA_out_24)
    );

    always #12.5 clk = ~clk;

    // Reference model: occupancy as an integer, scoreboard of words.
    logic [22:0] sbq[$];
    int          m_occ = 0;
    bit          m_pend = 0;
    logic [22:0] m_pay = '0;
    bit          m_ovf = 0;
    int          m_out = 0;
    logic [23:0] m_j1 = '0;
    logic [23:0] m_j3 = '0;
    bit          m_par = 0;
    bit          live = 0;

    always @(posedge clk) begin
        bit rd;
        bit acc;
        live = 1;
        if (RESET) begin
            sbq.delete();
            m_occ  = 0;
            m_pend = 0;
            m_ovf  = 0;
            m_out  = 0;
            m_j1   = '0;
            m_j3   = '0;
            m_par  = 0;
        end else begin
            rd  = (m_occ > 0) && J1DATA_25;
            acc = m_pend && (m_occ < 16);
            if (m_pend && !acc) m_ovf = 1;
            if (rd) m_occ = m_occ - 1;
            if (acc) begin
                m_occ = m_occ + 1;
                sbq.push_back(m_pay);
                m_out = (m_out + 1) % 32768;
                m_j1  = {1'b0, m_pay};
            end
            m_pend = !W1_DATA[23];
            m_pay  = W1_DATA[22:0];
            m_j3   = J3DATA_in;
            m_par  = ^J3DATA_in;
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
        end
    endtask

    // Monitor: flags every cycle, data against scoreboard head.
    always @(negedge clk) begin
        if (live) begin
            chk("dv", 32'(J1DATA_out[23]), 32'(m_occ > 0));
            chk("empty", 32'(FLOATIN_3), 32'(m_occ == 0));
            chk("hold", 32'(W_HOLD_2), 32'(m_occ >= 12));
            chk("ovf", 32'(FLOATIN_4), 32'(m_ovf));
            chk("out", 32'(OUT), 32'(m_out));
            chk("j1data", 32'(J1DATA), 32'(m_j1));
            chk("j3data", 32'(J3DATA), 32'(m_j3));
            chk("j3par", 32'(J3DATA_out_24), 32'(m_par));
            if (J1DATA_out[23]) begin
                if (sbq.size() == 0) begin
                    chk("sb_empty", 32'(J1DATA_out), 32'h0);
                end else if (J1DATA_25) begin
                    chk("j1word", 32'(J1DATA_out), {9'h0, 1'b1, sbq.pop_front()});
                end else begin
                    chk("j1hold", 32'(J1DATA_out), {9'h0, 1'b1, sbq[0]});
                end
            end else begin
                chk("j1zero", 32'(J1DATA_out), 32'h0);
            end
        end
    end

    task automatic step(input logic [23:0] w, input logic re);
        W1_DATA   = w;
        J1DATA_25 = re;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input logic re);
        for (int i = 0; i < n; i++) step(24'h800000, re);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET     = 1'b1;
        W1_DATA   = 24'h800000;
        J1DATA_25 = 1'b0;
        J3DATA_in = '0;
        idle(3, 1'b0);
        RESET = 1'b0;
        idle(3, 1'b0);

        step(24'h000123, 1'b0);
        idle(5, 1'b0);
        chk("lat_word", 32'(J1DATA_out), 32'h800123);
        idle(1, 1'b1);
        idle(2, 1'b0);

        for (int i = 1; i <= 3; i++) step(24'(i), 1'b0);
        idle(6, 1'b1);

        for (int i = 0; i < 17; i++) step(24'(i), 1'b0);
        idle(3, 1'b0);
        chk("fill_out", 32'(OUT), 32'(m_out));
        chk("fill_ovf", 32'(FLOATIN_4), 32'h1);
        idle(20, 1'b1);

        for (int i = 0; i < 30; i++) step({1'b0, 23'($urandom)}, 1'b1);
        idle(5, 1'b1);

        for (int i = 0; i < 40; i++)
            step({1'(i % 2), 23'($urandom)}, 1'($urandom_range(0, 1)));
        idle(20, 1'b1);

        for (int i = 0; i < 300; i++) begin
            J3DATA_in = 24'($urandom);
            step({1'($urandom_range(0, 2) == 0), 23'($urandom)},
                 1'($urandom_range(0, 3) == 0));
        end
        idle(20, 1'b1);

        J3DATA_in = 24'h000007;
        idle(2, 1'b0);
        chk("j3_par7", 32'(J3DATA_out_24), 32'h1);

        for (int i = 0; i < 6; i++) step({1'b0, 23'($urandom)}, 1'b0);
        RESET = 1'b1;
        idle(1, 1'b0);
        RESET = 1'b0;
        chk("rst_empty", 32'(FLOATIN_3), 32'h1);
        idle(4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
